// File: rtl/vector_tail_sequencer.sv
// Multi-beat vector sequencer: steps an operation over VECTOR_MASK_LENGTH-element
// beats and emits registered prestart/body/tail masks for each beat.
module vts_lane #(
  parameter int LW   = 8,
  parameter int EW   = 12,
  parameter int LANE = 0
) (
  input  logic [EW-1:0] e_base,
  input  logic [LW-1:0] vstart,
  input  logic [LW-1:0] vl_eff,
  input  logic [LW-1:0] vlmax,
  output logic          prestart,
  output logic          body,
  output logic          tail
);
  logic [EW-1:0] e, vs_w, vl_w, vm_w;
  assign e    = e_base + EW'(LANE);
  assign vs_w = EW'(vstart);
  assign vl_w = EW'(vl_eff);
  assign vm_w = EW'(vlmax);

  assign prestart = (e < vs_w) && (e < vm_w);
  assign body     = (e >= vs_w) && (e < vl_w);
  assign tail     = (e >= vl_w) && (e < vm_w);
endmodule

module vector_tail_sequencer #(
  parameter int VECTOR_MASK_LENGTH  = 8,
  parameter int VECTOR_LENGTH_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [VECTOR_LENGTH_WIDTH-1:0] vector_start,
  input  logic [VECTOR_LENGTH_WIDTH-1:0] vector_length,
  input  logic [VECTOR_LENGTH_WIDTH-1:0] vector_length_max,
  output logic                           beat_valid,
  input  logic                           beat_ready,
  output logic [VECTOR_LENGTH_WIDTH-1:0] beat_index,
  output logic                           beat_last,
  output logic [VECTOR_MASK_LENGTH-1:0]  prestart_mask,
  output logic [VECTOR_MASK_LENGTH-1:0]  body_mask,
  output logic [VECTOR_MASK_LENGTH-1:0]  tail_mask,
  output logic                           busy,
  output logic                           done
);
  localparam int ML = VECTOR_MASK_LENGTH;
  localparam int LW = VECTOR_LENGTH_WIDTH;
  localparam int IW = $clog2(ML);
  localparam int EW = LW + IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [LW-1:0] vstart_q, vl_eff_q, vlmax_q;
  logic [LW:0]   beat_total_q;

  logic          accept, beat_fire, empty_in;
  logic [LW-1:0] vl_eff_in;
  logic [LW:0]   total_in;

  assign start_ready = (state_q == IDLE);
  assign beat_valid  = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

  assign accept    = start_valid && start_ready;
  assign beat_fire = beat_valid && beat_ready;
  assign vl_eff_in = (vector_length > vector_length_max) ? vector_length_max : vector_length;
  assign empty_in  = (vector_length_max == '0) || (vector_start >= vl_eff_in);
  assign total_in  = (LW+1)'((EW'(vector_length_max) + EW'(ML - 1)) >> IW);

  // Masks for the beat about to be loaded: beat 0 straight from the descriptor
  // on accept, otherwise the successor of the current beat.
  logic [LW-1:0] src_vstart, src_vl_eff, src_vlmax, next_idx;
  logic [LW:0]   src_total;
  logic          next_last;
  logic [EW-1:0] e_base;

  assign src_vstart = accept ? vector_start : vstart_q;
  assign src_vl_eff = accept ? vl_eff_in    : vl_eff_q;
  assign src_vlmax  = accept ? vector_length_max : vlmax_q;
  assign src_total  = accept ? total_in     : beat_total_q;
  assign next_idx   = accept ? '0 : beat_index + LW'(1);
  assign next_last  = ((LW+1)'(next_idx) + (LW+1)'(1)) == src_total;
  assign e_base     = EW'(next_idx) << IW;

  logic [ML-1:0] pre_d, body_d, tail_d;

  for (genvar g = 0; g < ML; g++) begin : g_lane
    vts_lane #(.LW(LW), .EW(EW), .LANE(g)) u_lane (
      .e_base   (e_base),
      .vstart   (src_vstart),
      .vl_eff   (src_vl_eff),
      .vlmax    (src_vlmax),
      .prestart (pre_d[g]),
      .body     (body_d[g]),
      .tail     (tail_d[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = empty_in ? DONE : RUN;
      RUN:     if (beat_fire && beat_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic load_beat, clear_beat;
  assign load_beat  = (accept && !empty_in) || (beat_fire && !beat_last);
  assign clear_beat = beat_fire && beat_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      vstart_q      <= '0;
      vl_eff_q      <= '0;
      vlmax_q       <= '0;
      beat_total_q  <= '0;
      beat_index    <= '0;
      beat_last     <= 1'b0;
      prestart_mask <= '0;
      body_mask     <= '0;
      tail_mask     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vstart_q     <= vector_start;
        vl_eff_q     <= vl_eff_in;
        vlmax_q      <= vector_length_max;
        beat_total_q <= total_in;
      end
      if (load_beat) begin
        beat_index    <= next_idx;
        beat_last     <= next_last;
        prestart_mask <= pre_d;
        body_mask     <= body_d;
        tail_mask     <= tail_d;
      end else if (clear_beat) begin
        beat_index    <= '0;
        beat_last     <= 1'b0;
        prestart_mask <= '0;
        body_mask     <= '0;
        tail_mask     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vector_tail_sequencer.sv
// Bench for vector_tail_sequencer: directed vector table, stall/reset sequences,
// and random descriptors checked against an element-level reference model.
module tb_vector_tail_sequencer;
  logic       clock = 1'b0;
  logic       reset;
  logic       start_valid, start_ready;
  logic [7:0] vector_start, vector_length, vector_length_max;
  logic       beat_valid, beat_ready;
  logic [7:0] beat_index;
  logic       beat_last;
  logic [7:0] prestart_mask, body_mask, tail_mask;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  vector_tail_sequencer #(.VECTOR_MASK_LENGTH(8), .VECTOR_LENGTH_WIDTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .start_valid       (start_valid),
    .start_ready       (start_ready),
    .vector_start      (vector_start),
    .vector_length     (vector_length),
    .vector_length_max (vector_length_max),
    .beat_valid        (beat_valid),
    .beat_ready        (beat_ready),
    .beat_index        (beat_index),
    .beat_last         (beat_last),
    .prestart_mask     (prestart_mask),
    .body_mask         (body_mask),
    .tail_mask         (tail_mask),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: each element of the register group is classified on its own.
  function automatic logic [7:0] mdl_mask(input int kind, input int b, input int vs,
                                          input int vle, input int vm);
    logic [7:0] m;
    int e;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      e = b * 8 + i;
      case (kind)
        0:       m[i] = (e < vs) && (e < vm);
        1:       m[i] = (e >= vs) && (e < vle);
        default: m[i] = (e >= vle) && (e < vm);
      endcase
    end
    return m;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_beat_valid"}, int'(beat_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_masks"}, int'({prestart_mask, body_mask, tail_mask}), 0);
    check({tag, "_index_last"}, int'({beat_index, beat_last}), 0);
  endtask

  task automatic issue(input int vs, input int vl, input int vm);
    start_valid       = 1'b1;
    vector_start      = 8'(vs);
    vector_length     = 8'(vl);
    vector_length_max = 8'(vm);
    tick();
    start_valid       = 1'b0;
    vector_start      = 8'($urandom);
    vector_length     = 8'($urandom);
    vector_length_max = 8'($urandom);
  endtask

  // Full-throughput run observed purely from the DUT; results compared by caller.
  task automatic run_observed(input int vs, input int vl, input int vm, output int nb,
                              output int cyc, output logic [7:0] p0, output logic [7:0] b0,
                              output logic [7:0] t0, output logic [7:0] pl,
                              output logic [7:0] bl, output logic [7:0] tl,
                              output logic lastflag);
    nb = 0; cyc = 0; lastflag = 1'b0;
    {p0, b0, t0, pl, bl, tl} = '0;
    beat_ready = 1'b1;
    issue(vs, vl, vm);
    while (!done && cyc < 40) begin
      if (beat_valid) begin
        if (nb == 0) {p0, b0, t0} = {prestart_mask, body_mask, tail_mask};
        {pl, bl, tl} = {prestart_mask, body_mask, tail_mask};
        lastflag = beat_last;
        nb++;
      end
      cyc++;
      tick();
    end
    if (!done) check("done_timeout", int'(done), 1);
    tick();
    check("idle_after_done", int'(start_ready), 1);
  endtask

  // Model-checked run with optional stalls and ignored start pulses while busy.
  task automatic run_model(input int vs, input int vl, input int vm, input int stall0,
                           input bit rnd);
    int vle, tot, stalls;
    bit empty;
    vle   = (vl < vm) ? vl : vm;
    tot   = (vm + 7) / 8;
    empty = (vm == 0) || (vs >= vle);
    check("start_ready_pre", int'(start_ready), 1);
    issue(vs, vl, vm);
    if (!empty) begin
      for (int b = 0; b < tot; b++) begin
        stalls = (b == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
        for (int s = 0; s <= stalls; s++) begin
          check("m_beat_valid", int'(beat_valid), 1);
          check("m_busy_ready", int'({busy, start_ready, done}), 3'b100);
          check("m_index", int'(beat_index), b);
          check("m_last", int'(beat_last), int'(b == tot - 1));
          check("m_prestart", int'(prestart_mask), int'(mdl_mask(0, b, vs, vle, vm)));
          check("m_body", int'(body_mask), int'(mdl_mask(1, b, vs, vle, vm)));
          check("m_tail", int'(tail_mask), int'(mdl_mask(2, b, vs, vle, vm)));
          if (s < stalls) begin
            beat_ready        = 1'b0;
            start_valid       = 1'($urandom);
            vector_start      = 8'($urandom);
            vector_length     = 8'($urandom);
            vector_length_max = 8'($urandom);
          end else begin
            beat_ready  = 1'b1;
            start_valid = 1'b0;
          end
          tick();
        end
      end
    end
    check("m_done", int'(done), 1);
    check("m_done_ready", int'(start_ready), 0);
    check_idle_outputs("m_done");
    beat_ready = 1'($urandom);
    tick();
    check("m_done_once", int'(done), 0);
    check("m_back_idle", int'(start_ready), 1);
    check_idle_outputs("m_idle");
  endtask

  typedef struct {
    int vs, vl, vm, nb;
    logic [7:0] p0, b0, t0, pl, bl, tl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nb, cyc;
    logic [7:0] p0, b0, t0, pl, bl, tl;
    logic lastflag;

    tbl[0] = '{0, 10, 16, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hFC};
    tbl[1] = '{3, 5, 8, 1, 8'h07, 8'h18, 8'hE0, 8'h07, 8'h18, 8'hE0};
    tbl[2] = '{0, 20, 12, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h00};
    tbl[3] = '{0, 0, 16, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{7, 7, 16, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{2, 30, 24, 3, 8'h03, 8'hFC, 8'h00, 8'h00, 8'hFF, 8'h00};
    tbl[6] = '{0, 5, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[7] = '{10, 12, 20, 3, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
    tbl[8] = '{254, 255, 255, 32, 8'hFF, 8'h00, 8'h00, 8'h3F, 8'h40, 8'h00};

    reset = 1'b1; start_valid = 1'b0; beat_ready = 1'b0;
    vector_start = '0; vector_length = '0; vector_length_max = '0;
    repeat (3) tick();
    check("rst_start_ready", int'(start_ready), 1);
    check("rst_done", int'(done), 0);
    check_idle_outputs("rst");
    reset = 1'b0;
    beat_ready = 1'b1;
    tick();
    check("ready_in_idle_no_effect", int'({beat_valid, done, start_ready}), 3'b001);

    for (int k = 0; k < 9; k++) begin
      run_observed(tbl[k].vs, tbl[k].vl, tbl[k].vm, nb, cyc, p0, b0, t0, pl, bl, tl, lastflag);
      check($sformatf("t%0d_beats", k), nb, tbl[k].nb);
      check($sformatf("t%0d_latency", k), cyc, tbl[k].nb);
      check($sformatf("t%0d_first", k), int'({p0, b0, t0}), int'({tbl[k].p0, tbl[k].b0, tbl[k].t0}));
      check($sformatf("t%0d_lastbeat", k), int'({pl, bl, tl}), int'({tbl[k].pl, tbl[k].bl, tbl[k].tl}));
      check($sformatf("t%0d_lastflag", k), int'(lastflag), int'(tbl[k].nb != 0));
    end

    // Backpressure on beat 0 with start pulses that must be ignored.
    run_model(0, 9, 16, 3, 1'b0);

    // Reset during beat 1 of a two-beat op: no done pulse afterwards.
    beat_ready = 1'b1;
    issue(0, 10, 16);
    tick();
    check("rst_mid_index", int'(beat_index), 1);
    reset = 1'b1;
    beat_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_mid_ready", int'(start_ready), 1);
    check("rst_mid_done", int'(done), 0);
    check_idle_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_done", int'({done, beat_valid}), 0);
    end

    for (int r = 0; r < 60; r++) begin
      int vm, vl, vs;
      vm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      vl = int'($urandom_range(0, vm + 6)) % 256;
      vs = int'($urandom_range(0, vm + 3)) % 256;
      run_model(vs, vl, vm, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
